gpio_pad_ctrl: RTL and testbench

GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

---
 rtl/gpio_pad_pkg.sv | 33 +++
 rtl/gpio_sync_edge.sv | 37 +++
 rtl/gpio_pad_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_pkg.sv
// Shared constants for the GPIO pad controller: register word indices,
// reset values and the bus handshake state encoding.
package gpio_pad_pkg;

  // Register word indices on the 4-bit bus address
  localparam logic [3:0] ADDR_OUT        = 4'd0;
  localparam logic [3:0] ADDR_OE         = 4'd1;
  localparam logic [3:0] ADDR_IE         = 4'd2;
  localparam logic [3:0] ADDR_CS         = 4'd3;
  localparam logic [3:0] ADDR_SL         = 4'd4;
  localparam logic [3:0] ADDR_PU         = 4'd5;
  localparam logic [3:0] ADDR_PD         = 4'd6;
  localparam logic [3:0] ADDR_IN         = 4'd7;
  localparam logic [3:0] ADDR_IPULL      = 4'd8;
  localparam logic [3:0] ADDR_IRQ_EN     = 4'd9;
  localparam logic [3:0] ADDR_IRQ_STATUS = 4'd10;
  localparam logic [3:0] ADDR_OUT_SET    = 4'd11;
  localparam logic [3:0] ADDR_OUT_CLR    = 4'd12;

  // Input-pad pull-down field starts at this bit of the IPULL word
  localparam int IPULL_PD_LSB = 8;

  // Per-bit reset values; IE powers up enabled so pads are readable at once
  localparam logic RST_CTRL_BIT = 1'b0;
  localparam logic RST_IE_BIT   = 1'b1;

  // Bus handshake: one request accepted, answered on the following cycle
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop synchronizer for a bundle of asynchronous pad inputs, plus a
// single-cycle rising-edge pulse computed on the synchronized value.
module gpio_sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;

  // Synchronizer chain and one-cycle history of the synchronized value.
  // Clearing all three stages means the first post-reset cycle sees
  // r_sync == r_prev == 0, so no spurious edge is flagged.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge input, giving a true two-stage pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: bus-mapped control registers for bidirectional and
// input-only pads, synchronized pad readback and rising-edge interrupts.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int NUM_BIDIR_PADS = 18,
  parameter int NUM_INPUT_PADS = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bus_valid,
  input  logic                      bus_we,
  input  logic [3:0]                bus_addr,
  input  logic [31:0]               bus_wdata,
  output logic                      bus_ready,
  output logic [31:0]               bus_rdata,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  input  logic [NUM_INPUT_PADS-1:0] input_in,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd,
  output logic                      irq
);

  localparam int NB = NUM_BIDIR_PADS;
  localparam int NI = NUM_INPUT_PADS;
  localparam int NT = NB + NI;  // all synchronized inputs, bidir in the LSBs

  bus_state_e    r_state;
  bus_state_e    w_state_next;
  logic          w_ready;
  logic          w_wr;
  logic          w_rd;
  logic [31:0]   w_rdata;
  logic          w_unused;

  logic [NB-1:0] r_out;
  logic [NB-1:0] r_oe;
  logic [NB-1:0] r_ie;
  logic [NB-1:0] r_cs;
  logic [NB-1:0] r_sl;
  logic [NB-1:0] r_pu;
  logic [NB-1:0] r_pd;
  logic [NI-1:0] r_ipu;
  logic [NI-1:0] r_ipd;
  logic [NT-1:0] r_irq_en;
  logic [NT-1:0] r_irq_status;
  logic [NT-1:0] w_w1c_mask;
  logic [NT-1:0] w_in_sync;
  logic [NT-1:0] w_rise;

  // Pad input synchronization and edge detection for every input at once
  gpio_sync_edge #(
    .WIDTH (NT)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_async ({input_in, bidir_in}),
    .o_sync  (w_in_sync),
    .o_rise  (w_rise)
  );

  // Bus handshake state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and ready; ready is masked by rst so an aborted transfer
  // never looks complete to the master
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: if (bus_valid) w_state_next = ST_RESP;
      ST_RESP: begin
        w_ready      = ~rst;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_wr = w_ready & bus_we;
  assign w_rd = w_ready & ~bus_we;

  // Control register writes, committed at the end of the response cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= {NB{RST_CTRL_BIT}};
      r_oe     <= {NB{RST_CTRL_BIT}};
      r_ie     <= {NB{RST_IE_BIT}};
      r_cs     <= {NB{RST_CTRL_BIT}};
      r_sl     <= {NB{RST_CTRL_BIT}};
      r_pu     <= {NB{RST_CTRL_BIT}};
      r_pd     <= {NB{RST_CTRL_BIT}};
      r_ipu    <= {NI{RST_CTRL_BIT}};
      r_ipd    <= {NI{RST_CTRL_BIT}};
      r_irq_en <= {NT{RST_CTRL_BIT}};
    end else if (w_wr) begin
      case (bus_addr)
        ADDR_OUT:     r_out    <= bus_wdata[NB-1:0];
        ADDR_OE:      r_oe     <= bus_wdata[NB-1:0];
        ADDR_IE:      r_ie     <= bus_wdata[NB-1:0];
        ADDR_CS:      r_cs     <= bus_wdata[NB-1:0];
        ADDR_SL:      r_sl     <= bus_wdata[NB-1:0];
        ADDR_PU:      r_pu     <= bus_wdata[NB-1:0];
        ADDR_PD:      r_pd     <= bus_wdata[NB-1:0];
        ADDR_IPULL: begin
          r_ipu <= bus_wdata[NI-1:0];
          r_ipd <= bus_wdata[IPULL_PD_LSB +: NI];
        end
        ADDR_IRQ_EN:  r_irq_en <= bus_wdata[NT-1:0];
        ADDR_OUT_SET: r_out    <= r_out | bus_wdata[NB-1:0];
        ADDR_OUT_CLR: r_out    <= r_out & ~bus_wdata[NB-1:0];
        default: ;  // IN, IRQ_STATUS (handled below) and unmapped words
      endcase
    end
  end

  assign w_w1c_mask = (w_wr && (bus_addr == ADDR_IRQ_STATUS)) ?
                      bus_wdata[NT-1:0] : '0;

  // Interrupt status: clear first, then OR in new edges so set wins
  always_ff @(posedge clk) begin
    if (rst) r_irq_status <= {NT{RST_CTRL_BIT}};
    else     r_irq_status <= (r_irq_status & ~w_w1c_mask) | w_rise;
  end

  // Read data mux, forced to zero outside a read response
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (bus_addr)
        ADDR_OUT:        w_rdata[NB-1:0] = r_out;
        ADDR_OE:         w_rdata[NB-1:0] = r_oe;
        ADDR_IE:         w_rdata[NB-1:0] = r_ie;
        ADDR_CS:         w_rdata[NB-1:0] = r_cs;
        ADDR_SL:         w_rdata[NB-1:0] = r_sl;
        ADDR_PU:         w_rdata[NB-1:0] = r_pu;
        ADDR_PD:         w_rdata[NB-1:0] = r_pd;
        ADDR_IN:         w_rdata[NT-1:0] = w_in_sync;
        ADDR_IPULL: begin
          w_rdata[NI-1:0]               = r_ipu;
          w_rdata[IPULL_PD_LSB +: NI]   = r_ipd;
        end
        ADDR_IRQ_EN:     w_rdata[NT-1:0] = r_irq_en;
        ADDR_IRQ_STATUS: w_rdata[NT-1:0] = r_irq_status;
        default:         w_rdata = '0;
      endcase
    end
  end

  assign bus_ready = w_ready;
  assign bus_rdata = w_rdata;

  // Pad drive: registers straight to pads; pull-up wins over pull-down
  assign bidir_out = r_out;
  assign bidir_oe  = r_oe;
  assign bidir_ie  = r_ie;
  assign bidir_cs  = r_cs;
  assign bidir_sl  = r_sl;
  assign bidir_pu  = r_pu;
  assign bidir_pd  = r_pd & ~r_pu;
  assign input_pu  = r_ipu;
  assign input_pd  = r_ipd & ~r_ipu;

  assign irq = |(r_irq_status & r_irq_en);

  // Write-data bits above the implemented register width are don't-care
  assign w_unused = ^bus_wdata;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: directed register table, multi-cycle
// interrupt/reset sequences, and a randomized run against a register model.
module tb_gpio_pad_ctrl;

  localparam int NB = 18;
  localparam int NI = 7;
  localparam logic [31:0] MASK_B = 32'h0003_FFFF;
  localparam logic [31:0] MASK_I = 32'h0000_007F;
  localparam logic [31:0] MASK_T = 32'h01FF_FFFF;

  localparam logic [3:0] A_OUT = 4'd0,  A_OE = 4'd1,  A_IE = 4'd2,  A_CS = 4'd3;
  localparam logic [3:0] A_SL = 4'd4,   A_PU = 4'd5,  A_PD = 4'd6,  A_IN = 4'd7;
  localparam logic [3:0] A_IPULL = 4'd8, A_EN = 4'd9, A_ST = 4'd10;
  localparam logic [3:0] A_SET = 4'd11, A_CLR = 4'd12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bus_valid = 1'b0;
  logic          bus_we = 1'b0;
  logic [3:0]    bus_addr = '0;
  logic [31:0]   bus_wdata = '0;
  logic          bus_ready;
  logic [31:0]   bus_rdata;
  logic [NB-1:0] bidir_in = '0;
  logic [NB-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
  logic [NI-1:0] input_in = '0;
  logic [NI-1:0] input_pu, input_pd;
  logic          irq;

  int total = 0;
  int bad   = 0;

  gpio_pad_ctrl #(.NUM_BIDIR_PADS(NB), .NUM_INPUT_PADS(NI)) dut (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .bidir_in(bidir_in), .bidir_out(bidir_out),
    .bidir_oe(bidir_oe), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
    .bidir_ie(bidir_ie), .bidir_pu(bidir_pu), .bidir_pd(bidir_pd),
    .input_in(input_in), .input_pu(input_pu), .input_pd(input_pd), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_out;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  // Register model used by the randomized phase
  logic [31:0] m_out, m_oe, m_ie, m_cs, m_sl, m_pu, m_pd, m_ipu, m_ipd;
  logic [31:0] m_en, m_st, m_pad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [3:0] addr,
                              input logic [31:0] wdata, input logic chk_rd,
                              input logic [31:0] exp_rd, input logic chk_out,
                              input logic [31:0] exp_out);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.chk_out = chk_out; v.exp_out = exp_out;
    return v;
  endfunction

  // Called #1 after a rising edge; returns #1 after the commit edge
  task automatic bus_xfer(input logic we, input logic [3:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    int  n;
    logic got;
    n = 0; got = 1'b0; rdata = '0;
    bus_valid = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    while (!got && n < 8) begin
      @(posedge clk); #1;
      n++;
      if (bus_ready) begin
        got   = 1'b1;
        rdata = bus_rdata;
      end
    end
    if (!got) check("bus_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      A_OUT:   return m_out;
      A_OE:    return m_oe;
      A_IE:    return m_ie;
      A_CS:    return m_cs;
      A_SL:    return m_sl;
      A_PU:    return m_pu;
      A_PD:    return m_pd;
      A_IN:    return m_pad;
      A_IPULL: return m_ipu | (m_ipd << 8);
      A_EN:    return m_en;
      A_ST:    return m_st;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [31:0] d);
    case (a)
      A_OUT:   m_out = d & MASK_B;
      A_OE:    m_oe  = d & MASK_B;
      A_IE:    m_ie  = d & MASK_B;
      A_CS:    m_cs  = d & MASK_B;
      A_SL:    m_sl  = d & MASK_B;
      A_PU:    m_pu  = d & MASK_B;
      A_PD:    m_pd  = d & MASK_B;
      A_IPULL: begin m_ipu = d & MASK_I; m_ipd = (d >> 8) & MASK_I; end
      A_EN:    m_en  = d & MASK_T;
      A_ST:    m_st  = m_st & ~d;
      A_SET:   m_out = m_out | (d & MASK_B);
      A_CLR:   m_out = m_out & ~d;
      default: ;
    endcase
  endtask

  task automatic check_pads();
    check("rnd_bidir_out", 32'(bidir_out), m_out);
    check("rnd_bidir_oe",  32'(bidir_oe),  m_oe);
    check("rnd_bidir_ie",  32'(bidir_ie),  m_ie);
    check("rnd_bidir_cs",  32'(bidir_cs),  m_cs);
    check("rnd_bidir_sl",  32'(bidir_sl),  m_sl);
    check("rnd_bidir_pu",  32'(bidir_pu),  m_pu);
    check("rnd_bidir_pd",  32'(bidir_pd),  m_pd & ~m_pu);
    check("rnd_input_pu",  32'(input_pu),  m_ipu);
    check("rnd_input_pd",  32'(input_pd),  m_ipd & ~m_ipu);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] newpad;
    logic [3:0]  a;
    logic [31:0] d;

    // ---------------- directed register table ----------------
    vecs.push_back(mk("oe_reset",    0, A_OE,    0,            1, 32'h0,     0, 0));
    vecs.push_back(mk("ie_reset",    0, A_IE,    0,            1, 32'h3FFFF, 0, 0));
    vecs.push_back(mk("out_reset",   0, A_OUT,   0,            1, 32'h0,     0, 0));
    vecs.push_back(mk("wr_out",      1, A_OUT,   32'h15,       0, 0,         1, 32'h15));
    vecs.push_back(mk("out_set",     1, A_SET,   32'h100,      0, 0,         1, 32'h115));
    vecs.push_back(mk("out_clr",     1, A_CLR,   32'h1,        0, 0,         1, 32'h114));
    vecs.push_back(mk("rd_out",      0, A_OUT,   0,            1, 32'h114,   0, 0));
    vecs.push_back(mk("wr_pu",       1, A_PU,    32'h3,        0, 0,         0, 0));
    vecs.push_back(mk("wr_pd",       1, A_PD,    32'h3,        0, 0,         0, 0));
    vecs.push_back(mk("wr_unmapped", 1, 4'd14,   32'hFFFFFFFF, 0, 0,         1, 32'h114));
    vecs.push_back(mk("rd_unmapped", 0, 4'd14,   0,            1, 32'h0,     0, 0));
    vecs.push_back(mk("rd_pu",       0, A_PU,    0,            1, 32'h3,     0, 0));
    vecs.push_back(mk("rd_pd",       0, A_PD,    0,            1, 32'h3,     0, 0));
    vecs.push_back(mk("rd_out_set",  0, A_SET,   0,            1, 32'h0,     0, 0));
    vecs.push_back(mk("wr_oe_all",   1, A_OE,    32'hFFFFFFFF, 0, 0,         0, 0));
    vecs.push_back(mk("rd_oe_mask",  0, A_OE,    0,            1, 32'h3FFFF, 0, 0));
    vecs.push_back(mk("wr_in",       1, A_IN,    32'hFFF,      0, 0,         0, 0));
    vecs.push_back(mk("rd_in",       0, A_IN,    0,            1, 32'h0,     0, 0));
    vecs.push_back(mk("rd_out_kept", 0, A_OUT,   0,            1, 32'h114,   0, 0));
    vecs.push_back(mk("wr_ipull",    1, A_IPULL, 32'h7F0F,     0, 0,         0, 0));
    vecs.push_back(mk("rd_ipull",    0, A_IPULL, 0,            1, 32'h7F0F,  0, 0));

    do_reset();
    check("irq_reset", 32'(irq), 32'd0);
    check("ready_reset", 32'(bus_ready), 32'd0);

    foreach (vecs[i]) begin
      bus_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
      if (vecs[i].chk_rd)  check(vecs[i].name, rd, vecs[i].exp_rd);
      if (vecs[i].chk_out) check({vecs[i].name, "_pad"}, 32'(bidir_out), vecs[i].exp_out);
    end
    check("rdata_idle",  bus_rdata, 32'h0);
    check("bidir_pu",    32'(bidir_pu), 32'h3);
    check("bidir_pd",    32'(bidir_pd), 32'h0);
    check("bidir_oe",    32'(bidir_oe), 32'h3FFFF);
    check("input_pu",    32'(input_pu), 32'h0F);
    check("input_pd",    32'(input_pd), 32'h70);

    // ---------------- edge -> status -> irq timing ----------------
    bus_xfer(1'b1, A_EN, 32'h8, rd);
    bidir_in[3] = 1'b1;
    @(posedge clk); #1; check("irq_cycle1", 32'(irq), 32'd0);
    @(posedge clk); #1; check("irq_cycle2", 32'(irq), 32'd0);
    @(posedge clk); #1; check("irq_cycle3", 32'(irq), 32'd1);
    bus_xfer(1'b0, A_IN, 0, rd); check("in_bit3", rd, 32'h8);
    bus_xfer(1'b0, A_ST, 0, rd); check("status_bit3", rd, 32'h8);
    bus_xfer(1'b1, A_ST, 32'h8, rd); check("irq_after_w1c", 32'(irq), 32'd0);
    bus_xfer(1'b0, A_ST, 0, rd); check("status_cleared", rd, 32'h0);

    // IN latency: a read answered one cycle after the sampling edge shows
    // the old value; one answered two cycles after shows the new value
    bidir_in[4] = 1'b1;
    bus_xfer(1'b0, A_IN, 0, rd); check("in_lat_1cyc", rd, 32'h8);
    bidir_in[5] = 1'b1;
    @(posedge clk); #1;
    bus_xfer(1'b0, A_IN, 0, rd); check("in_lat_2cyc", rd, 32'h38);

    // ---------------- W1C colliding with a new edge ----------------
    bus_xfer(1'b1, A_ST, 32'hFFFFFFFF, rd);
    bidir_in[3] = 1'b0; repeat (4) @(posedge clk); #1;
    bidir_in[3] = 1'b1; repeat (4) @(posedge clk); #1;
    bus_xfer(1'b0, A_ST, 0, rd); check("st_before_collide", rd, 32'h8);
    bidir_in[3] = 1'b0; repeat (4) @(posedge clk); #1;
    bidir_in[3] = 1'b1;
    @(posedge clk); #1;
    bus_xfer(1'b1, A_ST, 32'h8, rd);
    bus_xfer(1'b0, A_ST, 0, rd); check("w1c_vs_edge", rd, 32'h8);
    check("irq_w1c_vs_edge", 32'(irq), 32'd1);

    // ---------------- reset during a write response ----------------
    bidir_in = '0;
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = A_OE; bus_wdata = 32'h3FFFF;
    @(posedge clk); #1;
    check("abort_in_resp", 32'(bus_ready), 32'd1);
    rst = 1'b1;
    #1 check("abort_ready_low", 32'(bus_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus_valid = 1'b0; bus_we = 1'b0;
    check("abort_oe", 32'(bidir_oe), 32'h0);
    check("abort_ready_idle", 32'(bus_ready), 32'd0);
    bus_xfer(1'b1, A_OE, 32'h5, rd);
    check("post_abort_oe_pad", 32'(bidir_oe), 32'h5);
    bus_xfer(1'b0, A_OE, 0, rd); check("post_abort_oe_rd", rd, 32'h5);

    // ---------------- randomized run against the register model ----------------
    bidir_in = '0; input_in = '0;
    do_reset();
    m_out = 0; m_oe = 0; m_ie = MASK_B; m_cs = 0; m_sl = 0; m_pu = 0; m_pd = 0;
    m_ipu = 0; m_ipd = 0; m_en = 0; m_st = 0; m_pad = 0;
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          newpad = $urandom & MASK_T;
          m_st  = m_st | (newpad & ~m_pad);
          m_pad = newpad;
          {input_in, bidir_in} = newpad[NB+NI-1:0];
          repeat (4) @(posedge clk); #1;
        end
        1, 2: begin
          a = 4'($urandom_range(0, 15));
          d = $urandom;
          bus_xfer(1'b1, a, d, rd);
          model_write(a, d);
          check_pads();
        end
        default: begin
          a = 4'($urandom_range(0, 15));
          bus_xfer(1'b0, a, 0, rd);
          check("rnd_read", rd, model_read(a));
        end
      endcase
      check("rnd_irq", 32'(irq), 32'(|(m_st & m_en)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
